// File: rtl/alu_add_serial.sv
// rtl/alu_add_serial.sv - multi-cycle nibble-serial 32-bit add/subtract unit
//
// Purpose: adds or subtracts two WIDTH-bit operands one 4-bit carry-select
// slice per clock, least significant nibble first. It reports sum, carry,
// signed overflow and zero, and uses a start/busy/done handshake.
//
// Ports:
//   clk   in   1      rising-edge clock
//   rst   in   1      synchronous reset, active-high
//   start in   1      request, sampled only when IDLE or DONE
//   sub   in   1      0: a+b, 1: a-b (sampled with start)
//   a     in   WIDTH  operand A (sampled with start)
//   b     in   WIDTH  operand B (sampled with start)
//   busy  out  1      high while the slices are being computed
//   done  out  1      one-cycle pulse, results valid from this cycle
//   sum   out  WIDTH  result (modulo 2^WIDTH)
//   co    out  1      carry out of MSB (for sub: 1 = no borrow)
//   ov    out  1      signed overflow
//   zero  out  1      sum == 0
module alu_add_serial #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ov,
    output logic             zero
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_b_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] sum_q;
    logic             co_q, ov_q, zero_q;

    logic             accept;
    logic             last_slice;
    logic [3:0]       a_nib, b_nib;
    logic [4:0]       slice_c0, slice_c1, slice_r;
    logic             carry_into_msb;

    // Operands may only be taken when no operation is in flight.
    assign accept     = start && (state_q != S_RUN);
    assign last_slice = (idx_q == IW'(N - 1));

    // Nibble select; {idx,2'b00} is the bit offset of slice idx.
    assign a_nib = op_a_q[{idx_q, 2'b00} +: 4];
    assign b_nib = op_b_q[{idx_q, 2'b00} +: 4];

    // Carry-select slice: both carry-in cases are formed in parallel and the
    // registered carry from the previous slice picks one.
    assign slice_c0 = {1'b0, a_nib} + {1'b0, b_nib};
    assign slice_c1 = {1'b0, a_nib} + {1'b0, b_nib} + 5'd1;
    assign slice_r  = carry_q ? slice_c1 : slice_c0;

    always_comb begin
        acc_d = acc_q;
        acc_d[{idx_q, 2'b00} +: 4] = slice_r[3:0];
    end

    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly.
    assign carry_into_msb = op_a_q[WIDTH-1] ^ op_b_q[WIDTH-1] ^ acc_d[WIDTH-1];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = start ? S_RUN : S_IDLE;
            S_RUN:   state_d = last_slice ? S_DONE : S_RUN;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            zero_q  <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
            op_a_q  <= a;
            op_b_q  <= sub ? ~b : b;
            carry_q <= sub;
            idx_q   <= '0;
        end else if (state_q == S_RUN) begin
            acc_q   <= acc_d;
            carry_q <= slice_r[4];
            idx_q   <= idx_q + IW'(1);
            // Visible results change only once, on the edge entering DONE.
            if (last_slice) begin
                sum_q  <= acc_d;
                co_q   <= slice_r[4];
                ov_q   <= carry_into_msb ^ slice_r[4];
                zero_q <= (acc_d == '0);
            end
        end
    end

    assign sum  = sum_q;
    assign co   = co_q;
    assign ov   = ov_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_alu_add_serial.sv
// tb/tb_alu_add_serial.sv - scoreboard bench for alu_add_serial
module tb_alu_add_serial;

    localparam int W = 32;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, co, ov, zero;
    logic [W-1:0] sum;

    alu_add_serial #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .sub  (sub),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .co   (co),
        .ov   (ov),
        .zero (zero)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] sum;
        logic         co;
        logic         ov;
        logic         zero;
        int unsigned  acc;
    } exp_t;

    exp_t sbq[$];
    exp_t last_e;
    int   checks = 0;
    int   failures = 0;
    logic done_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain 33-bit arithmetic and the textbook signed-overflow rule.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input int unsigned acc);
        exp_t        e;
        logic [W:0]  full;
        if (s) full = {1'b0, x} - {1'b0, y} + 33'h1_0000_0000;
        else   full = {1'b0, x} + {1'b0, y};
        e.sum  = full[W-1:0];
        e.co   = full[W];
        e.ov   = s ? ((x[W-1] != y[W-1]) && (e.sum[W-1] != x[W-1]))
                   : ((x[W-1] == y[W-1]) && (e.sum[W-1] != x[W-1]));
        e.zero = (e.sum == '0);
        e.acc  = acc;
        return e;
    endfunction

    // Monitor: compares on every done pulse, checks hold between pulses.
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            last_e.sum  = '0;
            last_e.co   = 1'b0;
            last_e.ov   = 1'b0;
            last_e.zero = 1'b0;
            last_e.acc  = 0;
            done_prev   = 1'b0;
        end else begin
            if (done) begin
                chk("done_pulse_width", {63'd0, done_prev}, 64'd0);
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("sum", {32'd0, sum}, {32'd0, e.sum});
                    chk("co", {63'd0, co}, {63'd0, e.co});
                    chk("ov", {63'd0, ov}, {63'd0, e.ov});
                    chk("zero", {63'd0, zero}, {63'd0, e.zero});
                    chk("latency", {32'd0, cyc - e.acc}, 64'(N));
                    last_e = e;
                end
            end else begin
                chk("hold_sum", {32'd0, sum}, {32'd0, last_e.sum});
                chk("hold_flags", {61'd0, co, ov, zero},
                    {61'd0, last_e.co, last_e.ov, last_e.zero});
            end
            done_prev = done;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Caller guarantees the DUT is in IDLE or DONE (busy low).
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        start = 1'b1;
        a     = x;
        b     = y;
        sub   = s;
        sbq.push_back(model(x, y, s, cyc + 1));
        tick();
        start = 1'b0;
        chk("busy_after_accept", {63'd0, busy}, 64'd1);
    endtask

    // Operand inputs are scrambled while waiting to show they are not re-sampled.
    task automatic wait_done;
        int n = 0;
        while (!done && n < 30) begin
            a   = $urandom;
            b   = $urandom;
            sub = $urandom_range(0, 1);
            tick();
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=0 required=1 (cycle %0d)", cyc);
        end
    endtask

    function automatic logic [W-1:0] pick_operand;
        logic [W-1:0] corners [4];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'hFFFF_FFFF;
        corners[2] = 32'h8000_0000;
        corners[3] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    initial begin
        // Reset state
        repeat (3) tick();
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_sum", {32'd0, sum}, 64'd0);
        chk("reset_flags", {61'd0, co, ov, zero}, 64'd0);
        rst = 1'b0;
        tick();

        // 1: carry out to zero
        issue(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        wait_done();
        tick();
        chk("done_falls", {63'd0, done}, 64'd0);
        tick();

        // 2 and 3: borrow, positive and negative overflow
        issue(32'h0000_0005, 32'h0000_0007, 1'b1);
        wait_done();
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        wait_done();
        issue(32'h8000_0000, 32'h0000_0001, 1'b1);
        wait_done();
        repeat (2) tick();

        // 4: start pulsed while busy is ignored
        issue(32'h1, 32'h2, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            a     = 32'h10;
            b     = 32'h20;
            sub   = 1'b0;
            tick();
        end
        start = 1'b0;
        wait_done();
        repeat (12) tick();
        chk("busy_idle_after_ignored", {63'd0, busy}, 64'd0);

        // 5: back-to-back start in the DONE cycle
        issue(32'h3, 32'h4, 1'b0);
        wait_done();
        issue(32'hA, 32'hA, 1'b1);
        wait_done();
        repeat (2) tick();

        // 6: reset mid-run aborts with no done and cleared outputs
        issue(32'h5, 32'h6, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("busy_after_rst", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        repeat (12) tick();
        issue(32'h1234_5678, 32'h0FED_CBA9, 1'b0);
        wait_done();

        // Random operations, mostly back-to-back with occasional idle gaps
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) repeat ($urandom_range(1, 3)) tick();
            issue(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
            wait_done();
        end
        repeat (3) tick();
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
